csr_trap_unit: RTL and testbench

Machine-mode CSR file and trap sequencer for the RV32I core. Sits in the execute/writeback boundary and consumes the main decoder's CSR controls (`csr_wtype`, pre-muxed write data) and trap requests (`trap_valid`, `trap_mcause`). It holds the M-mode trap CSRs and 64-bit counters, takes synchronous traps, the machine timer interrupt and `mret`, and issues a registered one-cycle PC redirect to fetch.

---
 rtl/csr_trap_unit.sv | 206 ++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// csr_trap_unit
//   Machine-mode CSR file and trap sequencer for the RV32I core. Holds the
//   M-mode trap CSRs and the 64-bit cycle/instret counters, takes synchronous
//   exceptions, the machine timer interrupt and MRET, and issues a registered
//   one-cycle PC redirect toward fetch.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   valid_i              instruction present; qualifies every request
//   csr_addr_i           CSR address (12b)
//   csr_wtype_i          0 none, 1 raw, 2 set, 3 clear
//   csr_wdata_i          pre-muxed write operand (rs1 or uimm)
//   csr_rdata_o          combinational read of csr_addr_i (pre-edge state)
//   csr_illegal_o        combinational: write to unsupported/read-only CSR
//   trap_valid_i         synchronous exception for this instruction
//   trap_mcause_i        exception code (31b)
//   trap_pc_i            PC of this instruction
//   trap_mtval_i         faulting value
//   mret_i               instruction is MRET
//   retire_i             instruction retires this cycle
//   irq_timer_i          level machine timer interrupt
//   redirect_valid_o     registered one-cycle redirect pulse
//   redirect_pc_o        registered redirect target
module csr_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_wtype_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        trap_valid_i,
  input  logic [30:0] trap_mcause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_mtval_i,
  input  logic        mret_i,
  input  logic        retire_i,
  input  logic        irq_timer_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTR    = 12'hC02;
  localparam logic [11:0] A_INSTRH   = 12'hC82;

  localparam logic [1:0] W_RAW = 2'd1;
  localparam logic [1:0] W_SET = 2'd2;
  localparam logic [1:0] W_CLR = 2'd3;

  // architectural state; low bits that always read zero are not stored
  logic        st_mie, st_mpie, mtie;
  logic [31:2] mtvec, mepc;
  logic [31:0] mscratch, mcause, mtval;
  logic [63:0] mcycle, minstret;

  logic        supported, writable;
  logic [31:0] rdata, wval;
  logic        accept, take_exc, take_irq, do_mret, do_write;

  // read mux plus decode of which addresses exist / accept writes
  always_comb begin
    rdata     = 32'h0;
    supported = 1'b1;
    writable  = 1'b1;
    case (csr_addr_i)
      A_MSTATUS:  rdata = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      A_MIE:      rdata = {24'b0, mtie, 7'b0};
      A_MTVEC:    rdata = {mtvec, 2'b00};
      A_MSCRATCH: rdata = mscratch;
      A_MEPC:     rdata = {mepc, 2'b00};
      A_MCAUSE:   rdata = mcause;
      A_MTVAL:    rdata = mtval;
      A_MIP: begin
        rdata    = {24'b0, irq_timer_i, 7'b0};
        writable = 1'b0;
      end
      A_MCYCLE:   rdata = mcycle[31:0];
      A_MCYCLEH:  rdata = mcycle[63:32];
      A_MINSTR:   rdata = minstret[31:0];
      A_MINSTRH:  rdata = minstret[63:32];
      A_CYCLE: begin
        rdata    = mcycle[31:0];
        writable = 1'b0;
      end
      A_CYCLEH: begin
        rdata    = mcycle[63:32];
        writable = 1'b0;
      end
      A_INSTR: begin
        rdata    = minstret[31:0];
        writable = 1'b0;
      end
      A_INSTRH: begin
        rdata    = minstret[63:32];
        writable = 1'b0;
      end
      default: begin
        supported = 1'b0;
        writable  = 1'b0;
      end
    endcase
  end

  assign csr_rdata_o   = rdata;
  assign csr_illegal_o = valid_i && (csr_wtype_i != 2'd0) && !(supported && writable);

  // read-modify-write operand; per-register masking happens at the flop
  always_comb begin
    case (csr_wtype_i)
      W_RAW:   wval = csr_wdata_i;
      W_SET:   wval = rdata | csr_wdata_i;
      W_CLR:   wval = rdata & ~csr_wdata_i;
      default: wval = rdata;
    endcase
  end

  // one request per instruction, ignored during the flush cycle after a redirect
  assign accept   = valid_i && !redirect_valid_o;
  assign take_exc = accept && trap_valid_i;
  assign take_irq = accept && !trap_valid_i && irq_timer_i && mtie && st_mie;
  assign do_mret  = accept && !trap_valid_i && !take_irq && mret_i;
  assign do_write = accept && !trap_valid_i && !take_irq && !mret_i &&
                    (csr_wtype_i != 2'd0) && !csr_illegal_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_mie           <= 1'b0;
      st_mpie          <= 1'b0;
      mtie             <= 1'b0;
      mtvec            <= RESET_MTVEC[31:2];
      mscratch         <= 32'h0;
      mepc             <= 30'h0;
      mcause           <= 32'h0;
      mtval            <= 32'h0;
      mcycle           <= 64'h0;
      minstret         <= 64'h0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= 32'h0;
    end else begin
      redirect_valid_o <= take_exc || take_irq || do_mret;
      // target uses pre-update mtvec/mepc
      if (take_exc || take_irq)
        redirect_pc_o <= {mtvec, 2'b00};
      else if (do_mret)
        redirect_pc_o <= {mepc, 2'b00};

      if (take_exc || take_irq) begin
        mepc    <= trap_pc_i[31:2];
        mcause  <= take_exc ? {1'b0, trap_mcause_i} : 32'h8000_0007;
        mtval   <= take_exc ? trap_mtval_i : 32'h0;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (do_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (do_write) begin
        case (csr_addr_i)
          A_MSTATUS: begin
            st_mie  <= wval[3];
            st_mpie <= wval[7];
          end
          A_MIE:      mtie     <= wval[7];
          A_MTVEC:    mtvec    <= wval[31:2];
          A_MSCRATCH: mscratch <= wval;
          A_MEPC:     mepc     <= wval[31:2];
          A_MCAUSE:   mcause   <= wval;
          A_MTVAL:    mtval    <= wval;
          default: ;
        endcase
      end

      // a write to either counter half replaces it and drops that cycle's increment
      if (do_write && csr_addr_i == A_MCYCLE)
        mcycle <= {mcycle[63:32], wval};
      else if (do_write && csr_addr_i == A_MCYCLEH)
        mcycle <= {wval, mcycle[31:0]};
      else
        mcycle <= mcycle + 64'd1;

      if (do_write && csr_addr_i == A_MINSTR)
        minstret <= {minstret[63:32], wval};
      else if (do_write && csr_addr_i == A_MINSTRH)
        minstret <= {wval, minstret[31:0]};
      else if (valid_i && retire_i)
        minstret <= minstret + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit. Inputs change 2ns after each rising edge,
// combinational outputs are sampled 1ns later, registered ones after the edge.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [11:0] addr;
  logic [1:0]  wtype;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        illegal;
  logic        trap_valid;
  logic [30:0] trap_mcause;
  logic [31:0] trap_pc;
  logic [31:0] trap_mtval;
  logic        mret;
  logic        retire;
  logic        irq_timer;
  logic        redir_valid;
  logic [31:0] redir_pc;

  int n_vec = 0;
  int n_err = 0;

  csr_trap_unit #(.RESET_MTVEC(32'h0000_0100)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .valid_i          (valid),
    .csr_addr_i       (addr),
    .csr_wtype_i      (wtype),
    .csr_wdata_i      (wdata),
    .csr_rdata_o      (rdata),
    .csr_illegal_o    (illegal),
    .trap_valid_i     (trap_valid),
    .trap_mcause_i    (trap_mcause),
    .trap_pc_i        (trap_pc),
    .trap_mtval_i     (trap_mtval),
    .mret_i           (mret),
    .retire_i         (retire),
    .irq_timer_i      (irq_timer),
    .redirect_valid_o (redir_valid),
    .redirect_pc_o    (redir_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    valid = 0; wtype = 0; wdata = 0; trap_valid = 0; trap_mcause = 0;
    trap_pc = 0; trap_mtval = 0; mret = 0; retire = 0;
  endtask

  // read with valid low so no side effects
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    idle();
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] t, input logic [31:0] d);
    idle();
    valid = 1; addr = a; wtype = t; wdata = d;
    #1;
  endtask

  initial begin
    rst_n = 0; irq_timer = 0; addr = 0;
    idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // reset state
    rd("rst_mtvec", 12'h305, 32'h0000_0100);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    chk("rst_redir_valid", {31'b0, redir_valid}, 32'h0);
    chk("rst_redir_pc", redir_pc, 32'h0);
    rd("rst_mscratch", 12'h340, 32'h0);

    // CSRRW / CSRRS / CSRRC return the old value
    wr(12'h340, 2'd1, 32'hA5A5_0000); chk("rw_old", rdata, 32'h0); cyc();
    wr(12'h340, 2'd2, 32'h0000_00FF); chk("rs_old", rdata, 32'hA5A5_0000); cyc();
    wr(12'h340, 2'd3, 32'hA500_000F); chk("rc_old", rdata, 32'hA5A5_00FF); cyc();
    rd("mscratch_final", 12'h340, 32'h00A5_00F0);

    wr(12'h300, 2'd1, 32'hFFFF_FFFF); cyc();
    rd("mstatus_mask", 12'h300, 32'h0000_1888);
    wr(12'h305, 2'd1, 32'h0000_0203); cyc();
    rd("mtvec_mask", 12'h305, 32'h0000_0200);

    // exception with a concurrent write that must be dropped
    wr(12'h340, 2'd1, 32'h1234_5678);
    trap_valid = 1; trap_mcause = 31'd2; trap_pc = 32'h200; trap_mtval = 32'hDEAD_BEEF;
    cyc();
    chk("exc_redir_valid", {31'b0, redir_valid}, 32'h1);
    chk("exc_redir_pc", redir_pc, 32'h0000_0200);
    // request during the flush cycle is ignored
    wr(12'h340, 2'd1, 32'h1111_1111);
    trap_valid = 1; trap_mcause = 31'd5; trap_pc = 32'h998; trap_mtval = 32'h5;
    cyc();
    chk("flush_redir_valid", {31'b0, redir_valid}, 32'h0);
    rd("exc_mepc", 12'h341, 32'h0000_0200);
    rd("exc_mcause", 12'h342, 32'h0000_0002);
    rd("exc_mtval", 12'h343, 32'hDEAD_BEEF);
    rd("exc_mstatus", 12'h300, 32'h0000_1880);
    rd("exc_mscratch_kept", 12'h340, 32'h00A5_00F0);

    // interrupt beats MRET
    wr(12'h300, 2'd2, 32'h0000_0008); cyc();
    rd("mie_restored", 12'h300, 32'h0000_1888);
    wr(12'h304, 2'd1, 32'hFFFF_FFFF); cyc();
    rd("mie_mask", 12'h304, 32'h0000_0080);
    irq_timer = 1;
    rd("mip_mtip", 12'h344, 32'h0000_0080);
    idle(); valid = 1; mret = 1; trap_pc = 32'h300; #1;
    cyc();
    chk("irq_redir_valid", {31'b0, redir_valid}, 32'h1);
    chk("irq_redir_pc", redir_pc, 32'h0000_0200);
    idle(); irq_timer = 0; cyc();
    rd("irq_mcause", 12'h342, 32'h8000_0007);
    rd("irq_mepc", 12'h341, 32'h0000_0300);
    rd("irq_mtval", 12'h343, 32'h0);
    rd("irq_mstatus", 12'h300, 32'h0000_1880);
    idle(); valid = 1; mret = 1; #1;
    cyc();
    chk("mret_redir_valid", {31'b0, redir_valid}, 32'h1);
    chk("mret_redir_pc", redir_pc, 32'h0000_0300);
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    cyc();

    // counter wrap
    wr(12'hB00, 2'd1, 32'hFFFF_FFFF); cyc();
    wr(12'hB80, 2'd1, 32'hFFFF_FFFF); cyc();
    rd("cyc_allones", 12'hB00, 32'hFFFF_FFFF);
    cyc();
    rd("cyc_wrap_lo", 12'hB00, 32'h0);
    rd("cyc_wrap_hi", 12'hB80, 32'h0);
    cyc();
    rd("cyc_lo_1", 12'hB00, 32'h1);
    rd("cycleh_alias", 12'hC80, 32'h0);

    // retire three instructions
    rd("instret_0", 12'hB02, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idle(); valid = 1; retire = 1; cyc();
    end
    rd("instret_3", 12'hB02, 32'h3);
    rd("instret_alias", 12'hC02, 32'h3);

    // illegal writes leave state alone
    wr(12'hC82, 2'd1, 32'hFFFF_FFFF);
    chk("illegal_c82", {31'b0, illegal}, 32'h1); cyc();
    rd("instreth_kept", 12'hB82, 32'h0);
    wr(12'hC00, 2'd1, 32'h5);
    chk("illegal_c00", {31'b0, illegal}, 32'h1); cyc();
    wr(12'h7C0, 2'd1, 32'hFFFF_FFFF);
    chk("illegal_7c0", {31'b0, illegal}, 32'h1); cyc();
    rd("unsup_read", 12'h7C0, 32'h0);
    rd("mscratch_kept", 12'h340, 32'h00A5_00F0);
    wr(12'h344, 2'd2, 32'h80);
    chk("illegal_mip", {31'b0, illegal}, 32'h1);
    idle(); valid = 1; addr = 12'hC00; #1;
    chk("legal_ro_read", {31'b0, illegal}, 32'h0);
    cyc();

    // reset during the redirect cycle
    idle(); valid = 1; trap_valid = 1; trap_mcause = 31'd3; trap_pc = 32'h44; #1;
    cyc();
    chk("pre_rst_redir", {31'b0, redir_valid}, 32'h1);
    idle();
    rst_n = 0; #1;
    chk("rst_kills_redir", {31'b0, redir_valid}, 32'h0);
    chk("rst_kills_pc", redir_pc, 32'h0);
    cyc();
    rst_n = 1;
    rd("rst2_mtvec", 12'h305, 32'h0000_0100);
    rd("rst2_mepc", 12'h341, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
